add_nbit: RTL and testbench

- Parameterised N-bit unsigned adder with a registered result.
- Sums two N-bit operands into an (N+1)-bit result and a separate carry-out flag.
- Built as a ripple chain of 1-bit full-adder cells; one register stage sits at the output.
- Used as the datapath adder primitive in the CPU; one-cycle latency lets it drop into pipelined stages.

---
 rtl/add_nbit.sv | 52 +++++
 tb/tb_add_nbit.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/add_nbit.sv
// add_nbit: N-bit unsigned ripple-carry adder with one output register stage.
// The (N+1)-bit sum and a separate carry-out flag are registered on every
// rising clock edge, giving a fixed one-cycle latency.
// Optional build macro ADD_NBIT_CARRY_IN_EN adds a c_in port feeding the
// carry into bit 0; without it the chain's carry-in is tied low.
module add_nbit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
`ifdef ADD_NBIT_CARRY_IN_EN
    input  logic         c_in,
`endif
    output logic [N:0]   out,
    output logic         c_out
);

    // carry[i] is the carry into bit i; carry[N] is the final carry-out.
    logic [N:0]   carry;
    logic [N-1:0] sum;

    // Carry into the least-significant cell.
`ifdef ADD_NBIT_CARRY_IN_EN
    assign carry[0] = c_in;
`else
    assign carry[0] = 1'b0;
`endif

    // Ripple chain of full-adder cells, one per operand bit.
    for (genvar i = 0; i < N; i++) begin : g_fa
        logic prop;
        assign prop         = a[i] ^ b[i];
        assign sum[i]       = prop ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & prop);
    end

    // ---- stage boundary: combinational sum -> registered result ----
    // Output register reloads every cycle; reset clears it asynchronously so
    // no pending result survives a reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out   <= '0;
            c_out <= 1'b0;
        end else begin
            out   <= {carry[N], sum};
            c_out <= carry[N];
        end
    end

endmodule

// File: tb/tb_add_nbit.sv
// tb_add_nbit: self-checking bench for add_nbit (N=8) using directed cases
// plus randomized operands compared against a plain-arithmetic model.
`timescale 1ns/1ps
module tb_add_nbit;

    localparam int N = 8;
`ifdef ADD_NBIT_CARRY_IN_EN
    localparam bit HAS_CIN = 1'b1;
`else
    localparam bit HAS_CIN = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic [N:0]   out;
    logic         c_out;

    int checks_total;
    int checks_passed;

    add_nbit #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .a     (a),
        .b     (b),
`ifdef ADD_NBIT_CARRY_IN_EN
        .c_in  (c_in),
`endif
        .out   (out),
        .c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: plain integer sum of the operands (carry-in only when the port exists).
    function automatic int model_sum(input int av, input int bv, input int cv);
        return av + bv + (HAS_CIN ? cv : 0);
    endfunction

    // Drive operands, confirm the output holds until the edge, then check after it.
    task automatic apply_and_check(input string tag, input int av, input int bv, input int cv,
                                   input int prev, input bit check_hold);
        int exp;
        a    = N'(av);
        b    = N'(bv);
        c_in = cv[0];
        exp  = model_sum(av, bv, cv);
        if (check_hold) begin
            #1;
            check({tag, "_hold"}, 32'(out), 32'(prev));
        end
        @(posedge clk);
        #1;
        check({tag, "_out"}, 32'(out), 32'(exp));
        check({tag, "_cout"}, 32'(c_out), 32'(exp >> N));
    endtask

    initial begin
        int av, bv, cv, exp, prev;
        checks_total  = 0;
        checks_passed = 0;
        rst  = 1'b0;
        a    = '1;
        b    = '1;
        c_in = 1'b0;

        // Asynchronous reset with no clock edge yet.
        #1 rst = 1'b1;
        #1;
        check("rst_async_out", 32'(out), 32'd0);
        check("rst_async_cout", 32'(c_out), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_held_out", 32'(out), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("rst_release_out", 32'(out), 32'd510);
        check("rst_release_cout", 32'(c_out), 32'd1);

        // Directed cases.
        apply_and_check("zero", 0, 0, 0, 510, 1'b0);
        apply_and_check("nocarry", 111, 100, 0, 0, 1'b1);
        apply_and_check("wrap", 255, 1, 0, 211, 1'b1);
        check("wrap_low", 32'(out[N-1:0]), 32'd0);
        apply_and_check("max_max", 255, 255, 0, 256, 1'b0);
        apply_and_check("b2b_0", 15, 1, 0, 0, 1'b0);
        apply_and_check("b2b_1", 128, 128, 0, 0, 1'b0);
        apply_and_check("b2b_2", 200, 55, 0, 0, 1'b0);

`ifdef ADD_NBIT_CARRY_IN_EN
        apply_and_check("cin_wrap", 255, 0, 1, 0, 1'b0);
        apply_and_check("cin_small", 10, 20, 1, 0, 1'b0);
`endif

        // Reset mid-operation discards the pending result.
        a = N'(200);
        b = N'(100);
        c_in = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out", 32'(out), 32'd0);
        @(posedge clk);
        #1;
        check("midrst_held", 32'(out), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_after", 32'(out), 32'd300);

        // Randomized operands, biased toward the extremes now and then.
        prev = 300;
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 7))
                0:       av = 0;
                1:       av = (1 << N) - 1;
                default: av = int'($urandom_range(0, (1 << N) - 1));
            endcase
            case ($urandom_range(0, 7))
                0:       bv = 0;
                1:       bv = (1 << N) - 1;
                default: bv = int'($urandom_range(0, (1 << N) - 1));
            endcase
            cv  = int'($urandom_range(0, 1));
            exp = model_sum(av, bv, cv);
            apply_and_check("rand", av, bv, cv, prev, (i % 16) == 0);
            check("rand_bitN", 32'(out[N]), 32'(c_out));
            prev = exp;
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    // Safety bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before %0t", $time);
        $fatal(1);
    end

endmodule
